// File: rtl/i2s_tx.sv
// i2s_tx: parametrised serial audio transmitter (I2S / left-justified, stereo or TDM).
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-high reset
//   data     in   CHANNELS*WIDTH frame samples, channel 0 in the MSBs, two's complement
//   valid    in   data holds a new frame
//   ready    out  one-clock pulse: data latched this cycle (frame start, valid high)
//   underrun out  one-clock pulse: frame start with valid low (previous frame repeats)
//   mck      out  free-running master clock, clock/(2*MCKDIV)
//   sck      out  bit clock, clock/(2*SCKDIV)
//   lr       out  word/frame select (low for the first half of the channel slots)
//   d        out  serial data, MSB first, zero-padded to SLOT bits, changes on sck falling
module i2s_tx #(
  parameter int SCKDIV   = 14,
  parameter int MCKDIV   = 2,
  parameter int WIDTH    = 16,
  parameter int SLOT     = 32,
  parameter int CHANNELS = 2,
  parameter int MODE     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS*WIDTH-1:0]    data,
  input  logic                         valid,
  output logic                         ready,
  output logic                         underrun,
  output logic                         mck,
  output logic                         sck,
  output logic                         lr,
  output logic                         d
);

  localparam int FW  = CHANNELS * WIDTH;
  localparam int SCW = (SCKDIV > 1) ? $clog2(SCKDIV) : 1;
  localparam int MCW = (MCKDIV > 1) ? $clog2(MCKDIV) : 1;
  localparam int BW  = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int CW  = $clog2(CHANNELS);

  logic [SCW-1:0] sck_cnt;
  logic [MCW-1:0] mck_cnt;
  // The bit counter n is held as (slot, bit-in-slot) so no division by SLOT is needed.
  logic [BW-1:0]  bit_q;
  logic [CW-1:0]  slot_q;
  logic [FW-1:0]  frame_q;

  logic           sck_tc, mck_tc, fe, wrap, bit_last, slot_last;
  logic [BW-1:0]  bit_n;
  logic [CW-1:0]  slot_n;
  logic [FW-1:0]  frame_n;
  logic           lr_n, d_n;

  // Bit b (MSB first) of channel s's slot; zero in the padding region.
  function automatic logic pick(input logic [FW-1:0] f, input logic [CW-1:0] s,
                                input logic [BW-1:0] b);
    int idx;
    if (int'(b) >= WIDTH) return 1'b0;
    idx = (CHANNELS - int'(s)) * WIDTH - 1 - int'(b);
    return |((f >> idx) & FW'(1));
  endfunction

  always_comb begin
    sck_tc    = (sck_cnt == SCW'(SCKDIV - 1));
    mck_tc    = (mck_cnt == MCW'(MCKDIV - 1));
    fe        = sck_tc && sck;
    bit_last  = (bit_q == BW'(SLOT - 1));
    slot_last = (slot_q == CW'(CHANNELS - 1));
    wrap      = fe && bit_last && slot_last;

    bit_n  = bit_last ? '0 : bit_q + 1'b1;
    slot_n = slot_q;
    if (bit_last) slot_n = slot_last ? '0 : slot_q + 1'b1;

    ready    = wrap && valid && !reset;
    underrun = wrap && !valid && !reset;
    frame_n  = (wrap && valid) ? data : frame_q;

    lr_n = (slot_n >= CW'(CHANNELS / 2));
    // Left-justified sends position n with the frame as it will be after this
    // edge (new frame at n=0). I2S sends position n-1, which is exactly the
    // pre-update counter against the pre-update frame, so the n=0 bit is the
    // tail of the previous frame's last slot.
    if (MODE == 1) d_n = pick(frame_n, slot_n, bit_n);
    else           d_n = pick(frame_q, slot_q, bit_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_cnt <= '0;
      mck_cnt <= '0;
      sck     <= 1'b0;
      mck     <= 1'b0;
      bit_q   <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      lr      <= 1'b0;
      d       <= 1'b0;
    end else begin
      sck_cnt <= sck_tc ? '0 : sck_cnt + 1'b1;
      mck_cnt <= mck_tc ? '0 : mck_cnt + 1'b1;
      if (sck_tc) sck <= ~sck;
      if (mck_tc) mck <= ~mck;
      if (fe) begin
        bit_q   <= bit_n;
        slot_q  <= slot_n;
        frame_q <= frame_n;
        lr      <= lr_n;
        d       <= d_n;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  typedef struct {
    logic [63:0] data;
    logic        valid;
    logic        exp_ready;
    logic        exp_underrun;
  } vec_t;

  localparam int NCFG = 5;
  localparam int C_SCK  [NCFG] = '{2, 2, 1, 3, 14};
  localparam int C_MCK  [NCFG] = '{2, 3, 1, 2, 2};
  localparam int C_W    [NCFG] = '{4, 4, 3, 8, 16};
  localparam int C_S    [NCFG] = '{4, 4, 5, 8, 32};
  localparam int C_CH   [NCFG] = '{2, 2, 4, 4, 2};
  localparam int C_MODE [NCFG] = '{1, 0, 0, 1, 0};
  localparam logic [63:0] C_D0 [NCFG] =
    '{64'hA5, 64'hA5, 64'h5A3, 64'h11223344, 64'h80017FFE};
  localparam logic [63:0] C_D2 [NCFG] =
    '{64'h3C, 64'h3C, 64'h9C6, 64'hA1B2C3D4, 64'h12345678};

  task automatic check(input int cfg, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %0h, expected %0h at %0t", cfg, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int SD = C_SCK[g];
    localparam int MD = C_MCK[g];
    localparam int W  = C_W[g];
    localparam int SL = C_S[g];
    localparam int CH = C_CH[g];
    localparam int MO = C_MODE[g];
    localparam int DW = CH * W;
    localparam int N  = CH * SL;
    localparam int P  = 2 * SD * N;          // clocks per frame
    localparam int NF = (g == 4) ? 4 : 7;
    localparam logic [63:0] MASK = (64'd1 << DW) - 64'd1;

    logic          reset = 1'b1;
    logic          valid = 1'b0;
    logic [DW-1:0] data  = '0;
    logic          ready, underrun, mck, sck, lr, d;

    i2s_tx #(.SCKDIV(SD), .MCKDIV(MD), .WIDTH(W), .SLOT(SL), .CHANNELS(CH), .MODE(MO)) dut (
      .clock(clock), .reset(reset), .data(data), .valid(valid), .ready(ready),
      .underrun(underrun), .mck(mck), .sck(sck), .lr(lr), .d(d)
    );

    vec_t vec[8];

    // Serial bit at stream position p of frame f, straight from the slot layout.
    function automatic logic ref_bit(input logic [63:0] f, input int p);
      int s, b;
      logic [63:0] t;
      s = p / SL;
      b = p % SL;
      if (b >= W) return 1'b0;
      t = f >> ((CH - s) * W - 1 - b);
      return t[0];
    endfunction

    // Starts at the negedge just after the reset edge E0; i counts edges since E0.
    task automatic run(input int v0, input int nf, input int abort_at);
      logic [63:0] frames[$];
      int k, n, m;
      logic exp_d;
      frames.push_back(64'd0);
      for (int j = 1; j <= nf; j++)
        frames.push_back(vec[v0+j-1].valid ? vec[v0+j-1].data : frames[j-1]);
      check(g, "rst_sck", {63'd0, sck}, 64'd0);
      check(g, "rst_mck", {63'd0, mck}, 64'd0);
      check(g, "rst_lr", {63'd0, lr}, 64'd0);
      check(g, "rst_d", {63'd0, d}, 64'd0);
      check(g, "rst_ready", {63'd0, ready}, 64'd0);
      check(g, "rst_underrun", {63'd0, underrun}, 64'd0);
      for (int i = 1; i < (nf + 1) * P; i++) begin
        if (abort_at != 0 && i == abort_at) break;
        if (i % P == 0) begin
          m     = i / P;
          data  = vec[v0+m-1].data[DW-1:0];
          valid = vec[v0+m-1].valid;
          #1;
          check(g, "ready_start", {63'd0, ready}, {63'd0, vec[v0+m-1].exp_ready});
          check(g, "underrun_start", {63'd0, underrun}, {63'd0, vec[v0+m-1].exp_underrun});
        end else begin
          data  = DW'($urandom);
          valid = 1'($urandom_range(0, 1));
          #1;
          check(g, "ready_idle", {63'd0, ready}, 64'd0);
          check(g, "underrun_idle", {63'd0, underrun}, 64'd0);
        end
        @(posedge clock);
        @(negedge clock);
        check(g, "sck", {63'd0, sck}, 64'((i / SD) % 2));
        check(g, "mck", {63'd0, mck}, 64'((i / MD) % 2));
        if (i % (2 * SD) == SD) begin
          k = (i + SD) / (2 * SD);
          n = (k - 1) % N;
          m = (k - 1) / N;
          if (MO == 1)     exp_d = ref_bit(frames[m], n);
          else if (n != 0) exp_d = ref_bit(frames[m], n - 1);
          else             exp_d = (m == 0) ? 1'b0 : ref_bit(frames[m-1], N - 1);
          check(g, "lr", {63'd0, lr}, {63'd0, ((n / SL) >= (CH / 2))});
          check(g, "d", {63'd0, d}, {63'd0, exp_d});
        end
      end
    endtask

    initial begin
      for (int i = 0; i < 8; i++) begin
        vec[i].data  = {$urandom, $urandom} & MASK;
        vec[i].valid = ($urandom_range(0, 3) != 0);
      end
      vec[0].data  = C_D0[g] & MASK;  vec[0].valid = 1'b1;
      vec[1].valid = 1'b1;
      vec[2].data  = C_D2[g] & MASK;  vec[2].valid = 1'b1;
      vec[3].valid = 1'b0;            // underrun: frame 2 repeats
      vec[4].valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        vec[i].exp_ready    = vec[i].valid;
        vec[i].exp_underrun = ~vec[i].valid;
      end

      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      run(0, NF, 0);

      // Fresh start, then a one-clock reset three quarters into frame 1.
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      run(0, 2, P + 2 * SD * (3 * N / 4) + SD);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check(g, "midrst_sck", {63'd0, sck}, 64'd0);
      check(g, "midrst_lr", {63'd0, lr}, 64'd0);
      check(g, "midrst_d", {63'd0, d}, 64'd0);
      run(4, 3, 0);
      n_done++;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && n_done < NCFG; t++) @(posedge clock);
    if (n_done < NCFG) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: configs done %0d, expected %0d", n_done, NCFG);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
